// File: rtl/semaforo_pkg.sv
// Shared semaforo definitions: request/light state codes,
// parameter defaults and counter helpers.
package semaforo_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int MIN_GREEN_DEF  = 8;
  localparam int RED_CYCLES_DEF = 16;
  localparam int CNT_W          = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'b00,
    REQ_PEND   = 2'b01,
    REQ_ASSERT = 2'b10
  } req_state_t;

  typedef enum logic [1:0] {
    LT_GRN = 2'b00,
    LT_YLW = 2'b01,
    LT_RED = 2'b10
  } light_state_t;

  function automatic cnt_t sat_inc(
    input cnt_t v,
    input cnt_t lim
  );
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/semaforo_debounce.sv
// Two-flop synchronizer followed by a level debouncer that
// needs DEB_CYCLES consecutive differing samples to toggle.
module semaforo_debounce
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam cnt_t LAST = CNT_W'(DEB_CYCLES - 1);

  logic s1;
  logic s2;
  logic db;
  cnt_t cnt;

  // metastability guard for the asynchronous sensor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // count differing samples; toggle once the run is long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      db  <= ~db;
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign dout = db;

endmodule

// File: rtl/semaforo_req_timer.sv
// Car request qualifier and red-phase timer for the
// semaforo light controller.
module semaforo_req_timer
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MIN_GREEN  = MIN_GREEN_DEF,
  parameter int RED_CYCLES = RED_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SENSOR,
  input  logic GRN,
  input  logic YLW,
  input  logic RED,
  output logic CAR,
  output logic TIMEOUT
);

  localparam cnt_t MG = CNT_W'(MIN_GREEN);
  localparam cnt_t RC = CNT_W'(RED_CYCLES);

  logic       db;
  cnt_t       g_cnt;
  cnt_t       r_cnt;
  req_state_t state;
  req_state_t state_nxt;

  semaforo_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (SENSOR),
    .dout (db)
  );

  // green and red run-length counters, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cnt <= '0;
      r_cnt <= '0;
    end else begin
      g_cnt <= GRN ? sat_inc(g_cnt, MG) : '0;
      r_cnt <= RED ? sat_inc(r_cnt, RC) : '0;
    end
  end

  // request state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // request transitions; a pending request survives db falling
  always_comb begin
    state_nxt = REQ_IDLE;
    unique case (state)
      REQ_IDLE:
        state_nxt = db ? REQ_PEND : REQ_IDLE;
      REQ_PEND:
        state_nxt = (GRN && (g_cnt == MG))
                  ? REQ_ASSERT : REQ_PEND;
      REQ_ASSERT:
        state_nxt = YLW ? REQ_IDLE : REQ_ASSERT;
      default:
        state_nxt = REQ_IDLE;
    endcase
  end

  assign CAR     = (state == REQ_ASSERT);
  assign TIMEOUT = RED && (r_cnt == RC);

endmodule

// File: tb/tb_semaforo_req_timer.sv
// Scoreboard bench for semaforo_req_timer: reference model,
// directed timing cases, random traffic and closed loop.
`timescale 1ns/1ps
module tb_semaforo_req_timer;
  import semaforo_pkg::*;

  localparam int DEB = DEB_CYCLES_DEF;
  localparam int MG  = MIN_GREEN_DEF;
  localparam int RC  = RED_CYCLES_DEF;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic sensor = 1'b0;
  logic grn    = 1'b0;
  logic ylw    = 1'b0;
  logic red    = 1'b0;
  logic car;
  logic timeout;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic car;
    logic to;
  } exp_t;

  exp_t q[$];

  semaforo_req_timer #(
    .DEB_CYCLES(DEB),
    .MIN_GREEN (MG),
    .RED_CYCLES(RC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SENSOR (sensor),
    .GRN    (grn),
    .YLW    (ylw),
    .RED    (red),
    .CAR    (car),
    .TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_s1, m_s2, m_db, m_pend, m_car, db_old;
  bit hist[$];
  int since, g_run, r_run;

  function automatic bit run_differs(input bit lvl);
    for (int i = 0; i < hist.size(); i++)
      if (hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_db = 0;
      m_pend = 0; m_car = 0;
      hist.delete();
      since = 0; g_run = 0; r_run = 0;
      q.delete();
      q.push_back(exp_t'{1'b0, 1'b0});
    end else begin
      db_old = m_db;
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      since++;
      if (since >= DEB && run_differs(db_old)) begin
        m_db = !m_db;
        since = 0;
      end
      if (m_car) begin
        if (ylw) m_car = 0;
      end else if (m_pend) begin
        if (grn && g_run >= MG) begin
          m_car = 1; m_pend = 0;
        end
      end else if (db_old) begin
        m_pend = 1;
      end
      g_run = grn ? g_run + 1 : 0;
      r_run = red ? r_run + 1 : 0;
      m_s2 = m_s1;
      m_s1 = sensor;
      #2;
      q.push_back(exp_t'{m_car, red && (r_run >= RC)});
    end
  end

  // monitor: compare DUT outputs against queued expectations
  exp_t e;
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (car !== e.car || timeout !== e.to) begin
        n_err++;
        $display("FAIL sb t=%0t car=%b timeout=%b need car=%b timeout=%b",
                 $time, car, timeout, e.car, e.to);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%b need=%b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d need=%0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_car", car, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // edges until CAR (sel=0) or TIMEOUT (sel=1) is high; -1 on expiry
  task automatic edges_until(input bit sel, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      cyc();
      n++;
      if (sel ? timeout : car) return;
    end
    n = -1;
  endtask

  int n, ph, len;
  bit pc, pt;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("init_car", car, 1'b0);
    chk("init_timeout", timeout, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // sensor qualification latency with green settled
    grn = 1'b1;
    repeat (20) cyc();
    sensor = 1'b1;
    edges_until(1'b0, 30, n);
    chk_int("car_latency", n, 8);
    repeat (5) cyc();
    chk("car_hold", car, 1'b1);
    ylw = 1'b1;
    cyc();
    chk("car_drop_ylw", car, 1'b0);
    ylw = 1'b0;

    // reset mid-request with red count at 10
    red = 1'b1;
    repeat (10) cyc();
    chk("pre_rst_car", car, 1'b1);
    chk("pre_rst_to", timeout, 1'b0);
    do_reset();
    edges_until(1'b0, 30, n);
    chk_int("requal_latency", n, 9);

    // red timeout timing and immediate drop
    red = 1'b0;
    cyc();
    red = 1'b1;
    edges_until(1'b1, 40, n);
    chk_int("timeout_latency", n, RC);
    red = 1'b0;
    #1;
    chk("to_drop", timeout, 1'b0);
    cyc();
    red = 1'b1;
    #1;
    chk("r_cnt_cleared", timeout, 1'b0);
    red = 1'b0;

    // short glitches never qualify
    sensor = 1'b0;
    do_reset();
    grn = 1'b1;
    repeat (8) begin
      sensor = 1'b1;
      repeat (3) begin cyc(); chk("glitch_car", car, 1'b0); end
      sensor = 1'b0;
      repeat (3) begin cyc(); chk("glitch_car", car, 1'b0); end
    end

    // green rising after db already qualified
    grn = 1'b0;
    do_reset();
    sensor = 1'b1;
    repeat (12) cyc();
    chk("no_car_wo_grn", car, 1'b0);
    grn = 1'b1;
    edges_until(1'b0, 30, n);
    chk_int("grn_latency", n, MG + 1);

    // randomized traffic
    do_reset();
    repeat (2000) begin
      cyc();
      if ($urandom_range(4) == 0) sensor = ~sensor;
      if ($urandom_range(11) == 0) grn = ~grn;
      ylw = ($urandom_range(9) == 0);
      if ($urandom_range(19) == 0) red = ~red;
      if ($urandom_range(299) == 0) do_reset();
    end

    // closed loop with a registered light controller
    sensor = 1'b1; grn = 1'b1; ylw = 1'b0; red = 1'b0;
    do_reset();
    ph = 0; len = 0; pc = 0; pt = 0;
    repeat (400) begin
      cyc();
      len++;
      chk_int("one_hot", int'(grn) + int'(ylw) + int'(red), 1);
      case (ph)
        0: if (pc) begin
          n_chk++;
          if (len < MG + 1) begin
            n_err++;
            $display("FAIL green_len got=%0d need>=%0d", len, MG + 1);
          end
          ph = 1; len = 0; grn = 0; ylw = 1;
        end
        1: begin
          chk("ylw_car_drop", car, 1'b0);
          ph = 2; len = 0; ylw = 0; red = 1;
        end
        default: if (pt) begin
          chk_int("red_len", len, RC + 1);
          ph = 0; len = 0; red = 0; grn = 1;
        end
      endcase
      @(negedge clk);
      pc = car;
      pt = timeout;
    end

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
